// File: rtl/pc_target_encoder_if.sv
// Bus bundle for pc_target_encoder: table write port, forward read port
// and the reverse-lookup request/result handshake.
interface pc_target_encoder_if;
   logic       WrEn;
   logic [3:0] WrAddr;
   logic [9:0] WrData;
   logic       Req;
   logic [9:0] Target;
   logic [3:0] RdAddr;
   logic [9:0] RdData;
   logic       Busy;
   logic       Done;
   logic       Hit;
   logic [3:0] Addr;

   modport master (
      output WrEn, WrAddr, WrData, Req, Target, RdAddr,
      input  RdData, Busy, Done, Hit, Addr
   );

   modport slave (
      input  WrEn, WrAddr, WrData, Req, Target, RdAddr,
      output RdData, Busy, Done, Hit, Addr
   );
endinterface

// File: rtl/pc_target_encoder.sv
// pc_target_encoder: 16 x 10-bit PC target table with a combinational
// forward read (index -> PC) and a sequential reverse lookup (PC -> lowest
// matching index), scanning one entry per clock.
// Optional feature macro: PCENC_DEFAULT_TABLE_EN -- when defined the table
// is loaded with fixed contents on reset; otherwise the table has no reset.
module pc_target_encoder (
   input  logic                 Clk,
   input  logic                 Reset_n,
   pc_target_encoder_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_e;

   logic [9:0] table_q [16];
   logic [9:0] table_d [16];

   state_e     state_q, state_d;
   logic [3:0] idx_q,   idx_d;
   logic [9:0] tgt_q,   tgt_d;
   logic       hit_q,   hit_d;
   logic [3:0] addr_q,  addr_d;
   logic       busy_q,  busy_d;
   logic       done_q,  done_d;

   // Table write: new value lands on the edge and is visible next cycle.
   always_comb begin
      table_d = table_q;
      if (bus.WrEn) table_d[bus.WrAddr] = bus.WrData;
   end

`ifdef PCENC_DEFAULT_TABLE_EN
   // Table storage with a fixed reset image.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         table_q[0] <= 10'd15;
         table_q[1] <= 10'd15;
         table_q[2] <= 10'd238;
         table_q[3] <= 10'd19;
         table_q[4] <= 10'd335;
         for (int i = 5; i < 16; i++) table_q[i] <= 10'(i);
      end else begin
         table_q <= table_d;
      end
   end
`else
   // Table storage without reset; contents are undefined until written.
   always_ff @(posedge Clk) begin
      table_q <= table_d;
   end
`endif

   // Scan control: accept Req in IDLE/DONE, walk indices 0..15 in SCAN,
   // stop on the first match (lowest index wins) or after index 15.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      tgt_d   = tgt_q;
      hit_d   = hit_q;
      addr_d  = addr_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (bus.Req) begin
               state_d = SCAN;
               tgt_d   = bus.Target;
               idx_d   = 4'd0;
               hit_d   = 1'b0;
               addr_d  = 4'd0;
            end
         end
         SCAN: begin
            if (table_q[idx_q] == tgt_q) begin
               state_d = DONE;
               hit_d   = 1'b1;
               addr_d  = idx_q;
            end else if (idx_q == 4'd15) begin
               // Last entry missed: finish without wrapping the index.
               state_d = DONE;
               hit_d   = 1'b0;
               addr_d  = 4'd0;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == SCAN);
      done_d = (state_d == DONE);
   end

   // FSM and result registers; reset aborts any scan silently.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         idx_q   <= 4'd0;
         tgt_q   <= 10'd0;
         hit_q   <= 1'b0;
         addr_q  <= 4'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         tgt_q   <= tgt_d;
         hit_q   <= hit_d;
         addr_q  <= addr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.RdData = table_q[bus.RdAddr];
   assign bus.Busy   = busy_q;
   assign bus.Done   = done_q;
   assign bus.Hit    = hit_q;
   assign bus.Addr   = addr_q;

endmodule

// File: tb/tb_pc_target_encoder.sv
// Directed bench for pc_target_encoder: loads the table, then runs reverse
// lookups for hit, duplicate, miss, mid-scan write, mid-scan reset,
// back-to-back and write-with-request cases against hand-computed results.
module tb_pc_target_encoder;

   logic Clk;
   logic Reset_n;
   int   n_cmp;
   int   n_err;
   int   e;
   int   bc;

   pc_target_encoder_if bus ();

   pc_target_encoder dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One-cycle Req pulse; returns just after the accepting edge (edge 0).
   task automatic start(input logic [9:0] t);
      bus.Req    = 1'b1;
      bus.Target = t;
      tick();
      bus.Req    = 1'b0;
   endtask

   // Counts edges until Done is seen (bounded) and cycles with Busy high.
   task automatic wait_done(output int edges, output int busy_cycles);
      edges       = 0;
      busy_cycles = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.Done) break;
         if (bus.Busy) busy_cycles++;
         tick();
         edges++;
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [9:0] d);
      bus.WrEn   = 1'b1;
      bus.WrAddr = a;
      bus.WrData = d;
      tick();
      bus.WrEn   = 1'b0;
   endtask

   initial begin
      logic [9:0] img [16];
      n_cmp = 0;
      n_err = 0;
      img[0] = 10'd15;  img[1] = 10'd15; img[2] = 10'd238;
      img[3] = 10'd19;  img[4] = 10'd335;
      for (int i = 5; i < 16; i++) img[i] = 10'(i);

      Reset_n    = 1'b0;
      bus.WrEn   = 1'b0;
      bus.WrAddr = 4'd0;
      bus.WrData = 10'd0;
      bus.Req    = 1'b0;
      bus.Target = 10'd0;
      bus.RdAddr = 4'd0;
      tick();
      tick();

      // Reset state
      chk("rst_busy", bus.Busy, 0);
      chk("rst_done", bus.Done, 0);
      chk("rst_hit",  bus.Hit,  0);
      chk("rst_addr", bus.Addr, 0);
`ifdef PCENC_DEFAULT_TABLE_EN
      bus.RdAddr = 4'd4;
      #1;
      chk("rst_tbl4", bus.RdData, 335);
`endif
      Reset_n = 1'b1;

      // Load the full table (default image values)
      for (int i = 0; i < 16; i++) wr(4'(i), img[i]);
      bus.RdAddr = 4'd2;
      #1;
      chk("rd2", bus.RdData, 238);
      bus.RdAddr = 4'd4;
      #1;
      chk("rd4", bus.RdData, 335);

      // Hit at index 2: Done after edge 3, Busy 3 cycles
      start(10'd238);
      chk("t238_busy0", bus.Busy, 1);
      wait_done(e, bc);
      chk("t238_edges", e, 3);
      chk("t238_busyc", bc, 3);
      chk("t238_hit",   bus.Hit, 1);
      chk("t238_addr",  bus.Addr, 2);
      tick();
      chk("t238_done1cyc", bus.Done, 0);
      chk("t238_idle",     bus.Busy, 0);
      chk("t238_hold_hit", bus.Hit, 1);
      chk("t238_hold_addr", bus.Addr, 2);

      // Duplicate 15 at 0 and 1: lowest wins, Done after edge 1
      start(10'd15);
      chk("t15_hitclr", bus.Hit, 0);
      wait_done(e, bc);
      chk("t15_edges", e, 1);
      chk("t15_hit",   bus.Hit, 1);
      chk("t15_addr",  bus.Addr, 0);
      tick();

      // Miss with an ignored second Req at edge 3: Done after edge 16
      start(10'd1000);
      tick();
      tick();
      bus.Req    = 1'b1;
      bus.Target = 10'd15;
      tick();
      bus.Req    = 1'b0;
      wait_done(e, bc);
      chk("miss_edges", e + 3, 16);
      chk("miss_hit",   bus.Hit, 0);
      chk("miss_addr",  bus.Addr, 0);
      tick();
      chk("miss_norestart_busy", bus.Busy, 0);
      chk("miss_norestart_done", bus.Done, 0);

      // Writes during scan: entry 9 (not yet compared) seen, entry 1 not
      start(10'd500);
      tick();
      tick();
      bus.WrEn   = 1'b1;
      bus.WrAddr = 4'd9;
      bus.WrData = 10'd500;
      tick();
      bus.WrAddr = 4'd1;
      tick();
      bus.WrEn   = 1'b0;
      wait_done(e, bc);
      chk("wr_edges", e + 4, 10);
      chk("wr_hit",   bus.Hit, 1);
      chk("wr_addr",  bus.Addr, 9);
      tick();

      // Fresh scan now sees entry 1 = 500 ahead of entry 9
      start(10'd500);
      wait_done(e, bc);
      chk("wr2_edges", e, 2);
      chk("wr2_addr",  bus.Addr, 1);
      tick();

      // Reset at scan edge 5: Busy drops at once, no Done
      start(10'd1000);
      repeat (5) tick();
      chk("ab_busy_pre", bus.Busy, 1);
      Reset_n = 1'b0;
      #1;
      chk("ab_busy", bus.Busy, 0);
      chk("ab_done", bus.Done, 0);
      tick();
      chk("ab_done_rst", bus.Done, 0);
      Reset_n = 1'b1;
      #1;
      chk("ab_done_rel", bus.Done, 0);
      start(10'd238);
      chk("ab_accept", bus.Busy, 1);
      wait_done(e, bc);
      chk("ab_edges", e, 3);
      chk("ab_addr",  bus.Addr, 2);

      // Back-to-back: Req in DONE cycle starts a scan with no idle gap
      bus.Req    = 1'b1;
      bus.Target = 10'd19;
      tick();
      bus.Req    = 1'b0;
      chk("b2b_busy", bus.Busy, 1);
      chk("b2b_hitclr", bus.Hit, 0);
      chk("b2b_addrclr", bus.Addr, 0);
      wait_done(e, bc);
      chk("b2b_edges", e, 4);
      chk("b2b_addr",  bus.Addr, 3);
      tick();

      // WrEn and Req together: scan compares the new value from edge 1
      bus.WrEn   = 1'b1;
      bus.WrAddr = 4'd0;
      bus.WrData = 10'd777;
      start(10'd777);
      bus.WrEn   = 1'b0;
      wait_done(e, bc);
      chk("wrreq_edges", e, 1);
      chk("wrreq_hit",   bus.Hit, 1);
      chk("wrreq_addr",  bus.Addr, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pc_target_encoder.md
PC_TARGET_ENCODER -- requirements
Module: pc_target_encoder

Interface
REQ-001 The block SHALL use one clock and one reset: the reset is asynchronous and active-low.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Reset_n  input  1  asynchronous active-low reset.
REQ-004 WrEn  input  1  write strobe for one table entry.
REQ-005 WrAddr  input  4  entry index for the write.
REQ-006 WrData  input  10  PC target value for the write.
REQ-007 Req  input  1  reverse-lookup request, a one-cycle pulse, accepted only while Busy=0.
REQ-008 Target  input  10  PC address to search for, sampled on the accepting edge.
REQ-009 RdAddr  input  4  forward lookup index.
REQ-010 RdData  output  10  combinational table[RdAddr] (pointer to PC direction).
REQ-011 Busy  output  1  high while a scan is in progress.
REQ-012 Done  output  1  one-cycle pulse when a scan completes.
REQ-013 Hit  output  1  last scan found a match; valid from Done and held until the next accepted Req.
REQ-014 Addr  output  4  lowest matching index; 0 on a miss; held like Hit.

Function
REQ-015 The table SHALL be 16 entries x 10 bits, written on the rising Clk edge when WrEn=1, and visible to RdData and to scan comparisons from the next cycle.
REQ-016 The FSM SHALL have three states: IDLE, SCAN and DONE.
REQ-017 In IDLE or DONE, with Req=1: capture Target, clear the index to 0, clear Hit and Addr, and go to SCAN. Req SHALL be ignored while in SCAN.
REQ-018 In SCAN, on each edge, compare table[index] with the captured Target.
REQ-019 On a match, go to DONE with Hit=1 and Addr=index; otherwise increment the index.
REQ-020 In SCAN, if index=15 and there is no match, go to DONE with Hit=0 and Addr=0. The 4-bit index SHALL never wrap within a scan.
REQ-021 DONE SHALL last exactly one cycle with Done=1, then go to IDLE unless a new Req is accepted.
REQ-022 Busy SHALL be 1 only in SCAN, and Done SHALL be 1 only in DONE.
REQ-023 Latency for a match at index k: Done SHALL be high in the cycle after edge k+1, counting the accepting edge as edge 0. A miss SHALL take 16 edges.
REQ-024 On duplicate entries, the lowest index SHALL win.
REQ-025 A write during SCAN to an entry not yet compared SHALL be seen by the scan. A write to an entry already compared SHALL not retrigger the scan.
REQ-026 When WrEn and Req occur in the same cycle, both SHALL take effect. The scan SHALL compare against the new value from edge 1 onward.

Reset
REQ-027 Reset_n=0 SHALL asynchronously force: state IDLE, index 0, captured target 0, Busy=0, Done=0, Hit=0, Addr=0.
REQ-028 A reset asserted mid-scan SHALL abort the scan with no Done pulse. After release, the block SHALL be idle and ready to accept Req on the first edge.
REQ-029 The table reset contents SHALL be set per REQ-030.

Configuration
REQ-030 Macro PCENC_DEFAULT_TABLE_EN:
- Defined: reset loads entries 0..4 = 15, 15, 238, 19, 335, and entries 5..15 = their own index (5..15).
- Not defined: the table has no reset; contents are undefined until written, and the bench SHALL write all 16 entries before the first Req.

Verification
REQ-031 With the macro defined, reset then Req with Target=238 -> Done one cycle after edge 3, Hit=1, Addr=2, Busy high for 3 cycles.
REQ-032 With the macro defined, Req with Target=15 -> Addr=0 (not 1), Hit=1, Done after edge 1.
REQ-033 Req with Target=1000 -> Done after edge 16, Hit=0, Addr=0, and a second Req during the scan is ignored.
REQ-034 Write entry 9=500 at edge 3 of an active scan for Target=500 -> Hit=1, Addr=9. A write to entry 1 during the same scan does not affect the result.
REQ-035 Reset_n pulsed low at scan edge 5 -> Busy=0 immediately, no Done pulse. A Req on the first cycle after reset release is accepted.
REQ-036 Back-to-back: Req asserted in the DONE cycle -> a new scan starts with no idle cycle, and Hit/Addr are cleared on that edge.
